clk_out_monitor: RTL

//  Downstream checker for the clock-select divider. It samples the divider output
//  (clk_in) as data in the pclk domain and counts its rising edges over a fixed pclk window.
//  It then compares the count against the ratio implied by sel and reports pass/fail.

---
 rtl/clk_mon_pkg.sv | 24 ++
 rtl/clk_mon_edge_cnt.sv | 38 +++
 rtl/clk_out_monitor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_mon_pkg
//  Brief    : Shared types and ratio helpers for the divider output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    // log2 of the division ratio selected by each sel code (/2, /4, /8, /16)
    localparam int c_RATIO_LOG2 [4] = '{1, 2, 3, 4};

    function automatic int exp_count(input logic [1:0] sel, input int window);
        return window >> c_RATIO_LOG2[sel];
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_mon_edge_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : clk_mon_edge_cnt
//  Brief    : Rising-edge detector with a saturating, clearable accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_mon_edge_cnt #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_sample,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_acc
);

    logic r_sample_d;
    logic w_rise;

    assign w_rise = i_sample & ~r_sample_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_d <= 1'b0;
            o_acc      <= '0;
        end else begin
            r_sample_d <= i_sample;
            if (i_clr) begin
                o_acc <= '0;
            end else if (i_en && w_rise && (o_acc != {CW{1'b1}})) begin
                o_acc <= o_acc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_out_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clk_out_monitor
//  Brief    : Counts divider-output rising edges over a pclk window and checks
//             the count against the ratio implied by sel.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_out_monitor
    import clk_mon_pkg::*;
#(
    parameter int WINDOW     = 256,
    parameter int SETTLE_CYC = 16,
    parameter int TOL        = 1,
    parameter int CW         = 9
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          clk_in,
    input  logic [1:0]    sel,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] edge_cnt,
    output logic          pass,
    output logic          sel_err
);

    localparam int c_CNT_W = $clog2((WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC);
    localparam int c_EW    = CW + 1;

    state_t             r_state;
    logic [1:0]         r_sel_q;
    logic [c_CNT_W-1:0] r_cnt;

    logic [CW-1:0]      w_acc;
    logic               w_sel_chg;
    logic               w_clr;
    logic               w_en;
    logic [c_EW-1:0]    w_exp;
    logic [c_EW-1:0]    w_diff;
    logic               w_in_tol;

    assign w_sel_chg = ((r_state == ST_SETTLE) || (r_state == ST_MEASURE)) && (sel != r_sel_q);
    assign w_clr     = ((r_state == ST_IDLE) && start) || w_sel_chg;
    assign w_en      = (r_state == ST_MEASURE) && !w_sel_chg;

    assign w_exp    = c_EW'(exp_count(r_sel_q, WINDOW));
    assign w_diff   = ({1'b0, w_acc} >= w_exp) ? ({1'b0, w_acc} - w_exp) : (w_exp - {1'b0, w_acc});
    assign w_in_tol = (w_diff <= c_EW'(TOL));

    clk_mon_edge_cnt #(
        .CW(CW)
    ) u_edge_cnt (
        .clk      (pclk),
        .rst_n    (presetn),
        .i_sample (clk_in),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .o_acc    (w_acc)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= ST_IDLE;
            r_sel_q  <= 2'b00;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            edge_cnt <= '0;
            pass     <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            sel_err <= 1'b0;
            if (w_sel_chg) begin
                // Restart the whole settle/measure sequence on the new ratio
                sel_err <= 1'b1;
                r_sel_q <= sel;
                r_cnt   <= '0;
                r_state <= ST_SETTLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_sel_q <= sel;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            r_state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == c_CNT_W'(SETTLE_CYC - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_MEASURE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (r_cnt == c_CNT_W'(WINDOW - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_CHECK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        edge_cnt <= w_acc;
                        pass     <= w_in_tol;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
